// File: rtl/hazard_pkg.sv
// hazard_pkg: shared constants for the hazard controller.
//   REG_W         register-number width
//   TW_DEF        default Tuse/Tnew field width
//   MULT_CYC_DEF  default multiply busy cycles
//   DIV_CYC_DEF   default divide busy cycles
//   FWD_RF        forward-select code meaning "take the register file value"
package hazard_pkg;
  localparam int REG_W        = 5;
  localparam int TW_DEF       = 2;
  localparam int MULT_CYC_DEF = 5;
  localparam int DIV_CYC_DEF  = 10;
  localparam int FWD_RF       = 0;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/hazard_stage_cmp.sv
// hazard_stage_cmp: compares one D-stage source register against one producer stage.
// Ports:
//   i_src     D-stage source register number (rs or rt)
//   i_wr_num  producer stage destination register
//   i_wr_en   producer stage register-write enable
//   i_tnew    producer Tnew (cycles until its result exists)
//   i_tuse    consumer Tuse (cycles until D needs the operand)
//   o_match   producer writes the register D reads ($zero never matches)
//   o_ready   match and result available now (forwardable)
//   o_stall   match and result will not be ready in time
module hazard_stage_cmp
  import hazard_pkg::*;
#(
  parameter int TW = TW_DEF
) (
  input  logic [REG_W-1:0] i_src,
  input  logic [REG_W-1:0] i_wr_num,
  input  logic             i_wr_en,
  input  logic [TW-1:0]    i_tnew,
  input  logic [TW-1:0]    i_tuse,
  output logic             o_match,
  output logic             o_ready,
  output logic             o_stall
);

  assign o_match = i_wr_en && (i_wr_num == i_src) && (i_src != '0);
  assign o_ready = o_match && (i_tnew == '0);
  assign o_stall = o_match && (i_tuse < i_tnew);

endmodule

// File: rtl/hazard_unit.sv
// hazard_unit: stall and forwarding control for the D stage of the five-stage pipeline.
// Optional feature macro: HAZARD_MDU_EN (multiply/divide busy tracking and MD stall).
// Ports:
//   clk, reset              clock, synchronous active-high reset (clears MDU counter)
//   d_instr                 D instruction; rs=[25:21], rt=[20:16]
//   d_tuse_rs, d_tuse_rt    Tuse of each source
//   d_is_md                 D instruction uses the MDU / HI / LO
//   wr_num, wr_en, tnew     per-stage producer info, stage 0 = E (youngest)
//   e_md_start, e_md_is_div MDU issue pulse in E and its divide qualifier
//   ifu_stall, d_reg_stall, e_reg_clr  freeze PC, freeze IF/D, bubble into D/E
//   fwd_rs, fwd_rt          forward selects: 0 = register file, i+1 = stage i
//   md_busy                 MDU counter non-zero
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int NSTAGE   = 3,
  parameter int TW       = TW_DEF,
  parameter int MULT_CYC = MULT_CYC_DEF,
  parameter int DIV_CYC  = DIV_CYC_DEF,
  localparam int SW      = $clog2(NSTAGE + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [31:0]             d_instr,
  input  logic [TW-1:0]           d_tuse_rs,
  input  logic [TW-1:0]           d_tuse_rt,
  input  logic                    d_is_md,
  input  logic [NSTAGE*REG_W-1:0] wr_num,
  input  logic [NSTAGE-1:0]       wr_en,
  input  logic [NSTAGE*TW-1:0]    tnew,
  input  logic                    e_md_start,
  input  logic                    e_md_is_div,
  output logic                    ifu_stall,
  output logic                    d_reg_stall,
  output logic                    e_reg_clr,
  output logic [SW-1:0]           fwd_rs,
  output logic [SW-1:0]           fwd_rt,
  output logic                    md_busy
);

  logic [REG_W-1:0]  w_rs;
  logic [REG_W-1:0]  w_rt;
  logic [NSTAGE-1:0] w_match_rs, w_match_rt;
  logic [NSTAGE-1:0] w_ready_rs, w_ready_rt;
  logic [NSTAGE-1:0] w_stall_rs, w_stall_rt;
  logic              w_data_stall;
  logic              w_md_stall;
  logic              w_stall;
  logic              w_unused;

  assign w_rs = d_instr[25:21];
  assign w_rt = d_instr[20:16];

  for (genvar g = 0; g < NSTAGE; g++) begin : g_stage
    hazard_stage_cmp #(.TW(TW)) u_cmp_rs (
      .i_src    (w_rs),
      .i_wr_num (wr_num[REG_W*g +: REG_W]),
      .i_wr_en  (wr_en[g]),
      .i_tnew   (tnew[TW*g +: TW]),
      .i_tuse   (d_tuse_rs),
      .o_match  (w_match_rs[g]),
      .o_ready  (w_ready_rs[g]),
      .o_stall  (w_stall_rs[g])
    );
    hazard_stage_cmp #(.TW(TW)) u_cmp_rt (
      .i_src    (w_rt),
      .i_wr_num (wr_num[REG_W*g +: REG_W]),
      .i_wr_en  (wr_en[g]),
      .i_tnew   (tnew[TW*g +: TW]),
      .i_tuse   (d_tuse_rt),
      .o_match  (w_match_rt[g]),
      .o_ready  (w_ready_rt[g]),
      .o_stall  (w_stall_rt[g])
    );
  end

  assign w_data_stall = |{w_stall_rs, w_stall_rt};

  // Scan oldest to youngest so the youngest ready producer overrides.
  always_comb begin
    fwd_rs = SW'(FWD_RF);
    fwd_rt = SW'(FWD_RF);
    for (int i = NSTAGE - 1; i >= 0; i--) begin
      if (w_ready_rs[i]) fwd_rs = SW'(i + 1);
      if (w_ready_rt[i]) fwd_rt = SW'(i + 1);
    end
  end

`ifdef HAZARD_MDU_EN
  localparam int CW = $clog2(max_int(MULT_CYC, DIV_CYC) + 1);

  logic [CW-1:0] r_md_cnt;

  // A start while already busy simply reloads; that case is illegal upstream.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_md_cnt <= '0;
    end else if (e_md_start) begin
      r_md_cnt <= e_md_is_div ? CW'(DIV_CYC) : CW'(MULT_CYC);
    end else if (r_md_cnt != '0) begin
      r_md_cnt <= r_md_cnt - CW'(1);
    end
  end

  assign md_busy    = (r_md_cnt != '0);
  // The issuing cycle itself must also hold an HI/LO consumer in D.
  assign w_md_stall = d_is_md && (md_busy || e_md_start);
  assign w_unused   = ^{d_instr[31:26], d_instr[15:0], w_match_rs, w_match_rt};
`else
  assign md_busy    = 1'b0;
  assign w_md_stall = 1'b0;
  assign w_unused   = ^{clk, reset, d_is_md, e_md_start, e_md_is_div,
                        d_instr[31:26], d_instr[15:0], w_match_rs, w_match_rt};
`endif

  assign w_stall     = w_data_stall | w_md_stall;
  assign ifu_stall   = w_stall;
  assign d_reg_stall = w_stall;
  assign e_reg_clr   = w_stall;

endmodule

// File: tb/tb_hazard_unit.sv
module tb_hazard_unit;
  import hazard_pkg::*;

  localparam int NS  = 3;
  localparam int TWL = 2;
  localparam int MC  = 5;
  localparam int DC  = 10;
  localparam int SWL = $clog2(NS + 1);
`ifdef HAZARD_MDU_EN
  localparam bit MDU_EN = 1'b1;
`else
  localparam bit MDU_EN = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 reset;
  logic [31:0]          d_instr;
  logic [TWL-1:0]       d_tuse_rs, d_tuse_rt;
  logic                 d_is_md;
  logic [NS*REG_W-1:0]  wr_num;
  logic [NS-1:0]        wr_en;
  logic [NS*TWL-1:0]    tnew;
  logic                 e_md_start, e_md_is_div;
  logic                 ifu_stall, d_reg_stall, e_reg_clr, md_busy;
  logic [SWL-1:0]       fwd_rs, fwd_rt;

  hazard_unit #(.NSTAGE(NS), .TW(TWL), .MULT_CYC(MC), .DIV_CYC(DC)) dut (
    .clk(clk), .reset(reset), .d_instr(d_instr),
    .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt), .d_is_md(d_is_md),
    .wr_num(wr_num), .wr_en(wr_en), .tnew(tnew),
    .e_md_start(e_md_start), .e_md_is_div(e_md_is_div),
    .ifu_stall(ifu_stall), .d_reg_stall(d_reg_stall), .e_reg_clr(e_reg_clr),
    .fwd_rs(fwd_rs), .fwd_rt(fwd_rt), .md_busy(md_busy)
  );

  always #5 clk = ~clk;

  // Abstract stimulus state
  int s_num[NS], s_en[NS], s_tnew[NS];
  int rs, rt, tuse_rs, tuse_rt, is_md, start, is_div, rst;

  // MDU model: cycle index and last cycle during which the unit is busy
  int cyc = 0;
  int busy_until = -1;

  int n_vec = 0;
  int n_err = 0;

  always @(posedge clk) begin
    if (rst != 0)        busy_until <= cyc;
    else if (start != 0) busy_until <= cyc + ((is_div != 0) ? DC : MC);
    cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic idle();
    for (int i = 0; i < NS; i++) begin
      s_num[i] = 0; s_en[i] = 0; s_tnew[i] = 0;
    end
    rs = 0; rt = 0; tuse_rs = 0; tuse_rt = 0;
    is_md = 0; start = 0; is_div = 0; rst = 0;
  endtask

  task automatic drive();
    logic [31:0] instr;
    instr = $urandom();
    instr[25:21] = 5'(rs);
    instr[20:16] = 5'(rt);
    d_instr   = instr;
    d_tuse_rs = TWL'(tuse_rs);
    d_tuse_rt = TWL'(tuse_rt);
    d_is_md   = (is_md != 0);
    for (int i = 0; i < NS; i++) begin
      wr_num[REG_W*i +: REG_W] = 5'(s_num[i]);
      wr_en[i]                 = (s_en[i] != 0);
      tnew[TWL*i +: TWL]       = TWL'(s_tnew[i]);
    end
    e_md_start  = (start != 0);
    e_md_is_div = (is_div != 0);
    reset       = (rst != 0);
  endtask

  // Reference: straight from the hazard rules, first ready stage wins.
  task automatic model(output int e_stall, output int e_fr, output int e_ft, output int e_busy);
    int data;
    bit m_rs, m_rt;
    data = 0; e_fr = 0; e_ft = 0;
    for (int i = 0; i < NS; i++) begin
      m_rs = (s_en[i] != 0) && (s_num[i] == rs) && (rs != 0);
      m_rt = (s_en[i] != 0) && (s_num[i] == rt) && (rt != 0);
      if (m_rs && tuse_rs < s_tnew[i]) data = 1;
      if (m_rt && tuse_rt < s_tnew[i]) data = 1;
      if (m_rs && s_tnew[i] == 0 && e_fr == 0) e_fr = i + 1;
      if (m_rt && s_tnew[i] == 0 && e_ft == 0) e_ft = i + 1;
    end
    e_busy  = (MDU_EN && cyc <= busy_until) ? 1 : 0;
    e_stall = (data != 0 || (MDU_EN && is_md != 0 && (e_busy != 0 || start != 0))) ? 1 : 0;
  endtask

  task automatic cyc_begin(input string tag);
    int e_stall, e_fr, e_ft, e_busy;
    drive();
    @(negedge clk);
    model(e_stall, e_fr, e_ft, e_busy);
    chk({tag, ".ifu_stall"},   ifu_stall,   e_stall);
    chk({tag, ".d_reg_stall"}, d_reg_stall, e_stall);
    chk({tag, ".e_reg_clr"},   e_reg_clr,   e_stall);
    chk({tag, ".fwd_rs"},      fwd_rs,      e_fr);
    chk({tag, ".fwd_rt"},      fwd_rt,      e_ft);
    chk({tag, ".md_busy"},     md_busy,     e_busy);
  endtask

  task automatic cyc_end();
    @(posedge clk);
    #1;
  endtask

  function automatic int pick_reg();
    case ($urandom % 5)
      0: return 0;
      1: return 8;
      2: return 9;
      3: return 10;
      default: return int'($urandom % 32);
    endcase
  endfunction

  initial begin
    idle();
    rst = 1;
    drive();
    @(posedge clk); #1;
    cyc_begin("reset");
    chk("reset.md_busy_zero", md_busy, 0);
    cyc_end();
    rst = 0;

    idle();
    cyc_begin("idle");
    chk("idle.stall_zero", ifu_stall, 0);
    cyc_end();

    // Load-use: E produces r8 in two cycles, D needs it in one
    idle();
    s_en[0] = 1; s_num[0] = 8; s_tnew[0] = 2; rs = 8; tuse_rs = 1;
    cyc_begin("loaduse");
    chk("loaduse.stall_one", ifu_stall, 1);
    chk("loaduse.fwd_rs_rf", fwd_rs, 0);
    cyc_end();

    // Two ready producers of r9: youngest wins
    idle();
    s_en[0] = 1; s_num[0] = 9; s_en[1] = 1; s_num[1] = 9; rt = 9; rs = 3;
    cyc_begin("fwdprio");
    chk("fwdprio.fwd_rt_e", fwd_rt, 1);
    chk("fwdprio.no_stall", ifu_stall, 0);
    cyc_end();

    // Young not-ready but in-time producer; older ready producer is forwarded
    idle();
    s_en[0] = 1; s_num[0] = 10; s_tnew[0] = 1; s_en[2] = 1; s_num[2] = 10; rs = 10; tuse_rs = 2;
    cyc_begin("olderfwd");
    chk("olderfwd.fwd_rs_w", fwd_rs, 3);
    cyc_end();

    // $zero never creates a hazard
    idle();
    s_en[0] = 1; s_num[0] = 0; s_tnew[0] = 2; rs = 0; tuse_rs = 0;
    cyc_begin("zero");
    chk("zero.no_stall", ifu_stall, 0);
    chk("zero.fwd_rs_rf", fwd_rs, 0);
    cyc_end();

    // Multiply at T, MD consumer held in D
    idle();
    is_md = 1; start = 1; is_div = 0;
    cyc_begin("mul_T");
    chk("mul.stall_T", ifu_stall, MDU_EN);
    cyc_end();
    start = 0;
    for (int k = 1; k <= 6; k++) begin
      cyc_begin("mul");
      chk("mul.busy_k",  md_busy,   (MDU_EN && k <= MC) ? 1 : 0);
      chk("mul.stall_k", ifu_stall, (MDU_EN && k <= MC) ? 1 : 0);
      cyc_end();
    end

    // Divide at T, reset at T+3
    idle();
    is_md = 1; start = 1; is_div = 1;
    cyc_begin("div_T");
    cyc_end();
    start = 0;
    for (int k = 1; k <= 2; k++) begin
      cyc_begin("div");
      cyc_end();
    end
    rst = 1;
    cyc_begin("div_rst");
    chk("divrst.busy_T3", md_busy, MDU_EN);
    cyc_end();
    rst = 0;
    cyc_begin("div_after");
    chk("divrst.busy_T4", md_busy, 0);
    chk("divrst.stall_T4", ifu_stall, 0);
    cyc_end();

    // Randomised traffic against the reference model
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NS; i++) begin
        s_num[i]  = pick_reg();
        s_en[i]   = int'($urandom % 4 != 0);
        s_tnew[i] = int'($urandom % 4);
      end
      rs      = pick_reg();
      rt      = pick_reg();
      tuse_rs = int'($urandom % 4);
      tuse_rt = int'($urandom % 4);
      is_md   = int'($urandom % 2);
      is_div  = int'($urandom % 2);
      if (cyc > busy_until) start = int'($urandom % 6 == 0);
      else                  start = int'($urandom % 40 == 0);
      rst = int'($urandom % 60 == 0);
      cyc_begin("rnd");
      cyc_end();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Parametrised hazard controller for the five-stage MIPS pipeline. It compares the D-stage source registers against the N producer stages to raise stall and forwarding selects. It also tracks a multi-cycle multiply/divide unit, so HI/LO-dependent instructions are held in D while that unit is busy. It sits beside the D stage and drives the PC/IF-D freeze, the D-E bubble insert and the D/E forwarding muxes.

## Interface
Parameters:
- NSTAGE, 3, number of producer stages tracked; index 0 = E (youngest), NSTAGE-1 = oldest (W)
- TW, 2, width of Tuse/Tnew fields
- MULT_CYC, 5, busy cycles after a multiply start
- DIV_CYC, 10, busy cycles after a divide start

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; clears MDU busy counter
- d_instr  in  32  D-stage instruction; rs=[25:21], rt=[20:16]
- d_tuse_rs  in  TW  Tuse of rs
- d_tuse_rt  in  TW  Tuse of rt
- d_is_md  in  1  D instruction is mult/div/mfhi/mflo/mthi/mtlo
- wr_num  in  NSTAGE*5  destination register of each stage; stage i at [5i+4:5i]
- wr_en  in  NSTAGE  register-write enable per stage
- tnew  in  NSTAGE*TW  Tnew per stage; stage i at [TW*i+TW-1:TW*i]
- e_md_start  in  1  mult/div issuing in E this cycle (pulse)
- e_md_is_div  in  1  qualifies e_md_start: 1 = divide, 0 = multiply
- ifu_stall  out  1  freeze PC
- d_reg_stall  out  1  freeze IF/D register
- e_reg_clr  out  1  load bubble into D/E register
- fwd_rs  out  SW  rs forward select; SW = $clog2(NSTAGE+1); 0 = register file, i+1 = stage i
- fwd_rt  out  SW  rt forward select, same encoding
- md_busy  out  1  MDU counter non-zero

## Operation
- match_x(i) = wr_en[i] && wr_num_i == x && x != 0, for x in {rs, rt}.
- Data stall: any i with match_rs(i) && d_tuse_rs < tnew_i, or match_rt(i) && d_tuse_rt < tnew_i. Comparisons are unsigned.
- Forward select: the lowest i with match and tnew_i == 0 gives i+1. With no such i, select is 0.
- A younger matching stage with tnew > 0 and tuse >= tnew does not stall. Its select is not chosen; an older ready stage may be selected. The pipeline re-evaluates next cycle.
- MDU counter md_cnt, width $clog2(max(MULT_CYC,DIV_CYC)+1):
  - reset takes priority and gives 0.
  - Else e_md_start loads DIV_CYC or MULT_CYC.
  - Else a non-zero count decrements by 1.
- md_busy = md_cnt != 0.
- MD stall: d_is_md && (md_busy || e_md_start).
- stall = data stall | MD stall. ifu_stall = d_reg_stall = e_reg_clr = stall.
- e_md_start while md_busy cannot occur legally, because D was stalled. If it does, the counter reloads and no error is flagged.

## Timing
- Stall and forward outputs are purely combinational from inputs and md_cnt, with zero latency.
- Reset values: md_cnt = 0, md_busy = 0.
- With all inputs idle after reset, all stall outputs are 0 and fwd selects are 0.
- A multiply started in cycle T holds md_busy high in cycles T+1 .. T+MULT_CYC.
- An MD instruction in D is stalled for cycles T .. T+MULT_CYC and proceeds at T+MULT_CYC+1.
- A reset asserted mid-count clears the counter at that edge; md_busy is 0 in the next cycle.

## Configuration
- HAZARD_MDU_EN defined: MDU counter and MD stall are present as described.
- HAZARD_MDU_EN undefined: counter is removed; md_busy is tied 0 and MD stall is 0; d_is_md, e_md_start and e_md_is_div are ignored.

## Structure
- Shared package hazard_pkg holds:
  - REG_W = 5
  - default TW, MULT_CYC and DIV_CYC
  - the forward-select encoding constant FWD_RF = 0
- One sub-module, hazard_stage_cmp, instantiated per stage by generate:
  - inputs: the reg number, wr_en, tnew, tuse
  - outputs: match, ready (match && tnew==0) and stall (match && tuse<tnew)

## Test plan
- Load-use: stage0 wr_num=8, wr_en=1, tnew=2; D rs=8, tuse_rs=1 -> stall=1; fwd_rs=0.
- Forward priority: stage0 and stage1 both write reg 9 with tnew=0; D rt=9 -> fwd_rt=1, stall=0.
- $zero: stage0 writes reg 0 with tnew=2; D rs=0, tuse=0 -> stall=0, fwd_rs=0.
- Multiply: e_md_start=1, e_md_is_div=0 at T, and d_is_md=1 held. Expected:
  - stall is high for cycles T..T+5.
  - md_busy is high for T+1..T+5.
  - stall is low at T+6.
- Divide with reset: divide start at T, then reset at T+3 -> md_busy=0 and stall=0 at T+4 with d_is_md=1.
- Build without HAZARD_MDU_EN: e_md_start=1 with d_is_md=1 -> stall=0, md_busy=0.
